// File: rtl/tdc_pulsegen_pkg.sv
// Shared definitions for the TDC pulse generator: CSR register indices,
// CTRL/STATUS bit positions and the pulse FSM state encoding.
package tdc_pulsegen_pkg;

    // Register indices within the CSR page (csr_a[2:0])
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PERIOD = 3'd1;
    localparam logic [2:0] REG_WIDTH  = 3'd2;
    localparam logic [2:0] REG_BURST  = 3'd3;
    localparam logic [2:0] REG_COUNT  = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;

    // CTRL and STATUS bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_START_BIT  = 1;
    localparam int STATUS_BUSY_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/tdc_pulsegen_csr.sv
// CSR page of the pulse generator: address decode, R/W register file and a
// registered read mux (one cycle read latency, zero when the page is not
// selected).
// Ports:
//   sys_clk, sys_rst_n  clock and asynchronous active-low reset
//   csr_a/we/di/do      shared CSR bus
//   count_i, busy_i     read-only values supplied by the pulse engine
//   enable_o            enable as seen this cycle (includes a CTRL write in flight)
//   start_o             one-cycle start strobe (CTRL write with bit1 set)
//   count_clr_o         one-cycle strobe on any write to COUNT
//   period_o, width_o, burst_o  programmed (unclamped) register values
// cnt_width is expected to be below 32.
module tdc_pulsegen_csr
    import tdc_pulsegen_pkg::*;
#(
    parameter logic [3:0] csr_addr  = 4'h2,
    parameter int         cnt_width = 24
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [13:0]          csr_a,
    input  logic                 csr_we,
    input  logic [31:0]          csr_di,
    output logic [31:0]          csr_do,
    input  logic [cnt_width-1:0] count_i,
    input  logic                 busy_i,
    output logic                 enable_o,
    output logic                 start_o,
    output logic                 count_clr_o,
    output logic [cnt_width-1:0] period_o,
    output logic [cnt_width-1:0] width_o,
    output logic [cnt_width-1:0] burst_o
);

    logic                 sel;
    logic                 wr;
    logic [2:0]           idx;
    logic                 ctrl_wr;
    logic                 enable_q;
    logic [cnt_width-1:0] period_q;
    logic [cnt_width-1:0] width_q;
    logic [cnt_width-1:0] burst_q;
    logic [31:0]          rdata;
    logic [31:0]          csr_do_d;
    logic [31:0]          csr_do_q;
    logic                 unused_bits;

    assign sel     = (csr_a[13:10] == csr_addr);
    assign idx     = csr_a[2:0];
    assign wr      = sel && csr_we;
    assign ctrl_wr = wr && (idx == REG_CTRL);

    // The engine reacts on the same edge as the CTRL write, so it sees the
    // value being written rather than the stored one.
    assign enable_o    = ctrl_wr ? csr_di[CTRL_EN_BIT] : enable_q;
    assign start_o     = ctrl_wr && csr_di[CTRL_START_BIT];
    assign count_clr_o = wr && (idx == REG_COUNT);

    assign period_o = period_q;
    assign width_o  = width_q;
    assign burst_o  = burst_q;

    assign unused_bits = ^{csr_a[9:3], csr_di[31:cnt_width]};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            enable_q <= 1'b0;
            period_q <= cnt_width'(2);
            width_q  <= cnt_width'(1);
            burst_q  <= '0;
        end else if (wr) begin
            case (idx)
                REG_CTRL:   enable_q <= csr_di[CTRL_EN_BIT];
                REG_PERIOD: period_q <= csr_di[cnt_width-1:0];
                REG_WIDTH:  width_q  <= csr_di[cnt_width-1:0];
                REG_BURST:  burst_q  <= csr_di[cnt_width-1:0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            REG_CTRL:   rdata[CTRL_EN_BIT]     = enable_q;
            REG_PERIOD: rdata[cnt_width-1:0]   = period_q;
            REG_WIDTH:  rdata[cnt_width-1:0]   = width_q;
            REG_BURST:  rdata[cnt_width-1:0]   = burst_q;
            REG_COUNT:  rdata[cnt_width-1:0]   = count_i;
            REG_STATUS: rdata[STATUS_BUSY_BIT] = busy_i;
            default:    rdata = '0;
        endcase
        csr_do_d = sel ? rdata : 32'd0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            csr_do_q <= 32'd0;
        end else begin
            csr_do_q <= csr_do_d;
        end
    end

    assign csr_do = csr_do_q;

endmodule

// File: rtl/tdc_pulsegen.sv
// Programmable pulse generator for the TDC test-signal path. Software sets
// PERIOD/WIDTH/BURST and starts a run; the engine emits a registered pulse
// train and flags the end of a finite burst with a one-cycle done_irq.
// Ports:
//   sys_clk, sys_rst_n  clock and asynchronous active-low reset
//   csr_a/we/di/do      shared CSR bus (csr_do is zero when not selected)
//   pulse_o             generated pulse, registered
//   done_irq            one-cycle pulse after the last low phase of a burst
module tdc_pulsegen
    import tdc_pulsegen_pkg::*;
#(
    parameter logic [3:0] csr_addr  = 4'h2,
    parameter int         cnt_width = 24
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        pulse_o,
    output logic        done_irq
);

    localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);

    logic                 enable;
    logic                 start;
    logic                 count_clr;
    logic [cnt_width-1:0] period;
    logic [cnt_width-1:0] width;
    logic [cnt_width-1:0] burst;
    logic [cnt_width-1:0] eff_w;
    logic [cnt_width-1:0] eff_p;

    state_e               state_q, state_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic [cnt_width-1:0] count_q, count_d;
    logic [cnt_width-1:0] w_sh_q, w_sh_d;
    logic [cnt_width-1:0] p_sh_q, p_sh_d;
    logic [cnt_width-1:0] b_sh_q, b_sh_d;
    logic                 pulse_q, pulse_d;
    logic                 done_q, done_d;

    tdc_pulsegen_csr #(
        .csr_addr  (csr_addr),
        .cnt_width (cnt_width)
    ) u_csr (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .csr_a       (csr_a),
        .csr_we      (csr_we),
        .csr_di      (csr_di),
        .csr_do      (csr_do),
        .count_i     (count_q),
        .busy_i      (state_q != ST_IDLE),
        .enable_o    (enable),
        .start_o     (start),
        .count_clr_o (count_clr),
        .period_o    (period),
        .width_o     (width),
        .burst_o     (burst)
    );

    // Clamp so that the pulse is at least one cycle high and at least one
    // cycle low. If width is all-ones, eff_w+1 wraps to 0; the period
    // counter also wraps to 0 exactly 2^cnt_width cycles in, so the
    // comparison still ends the period at the right time.
    assign eff_w = (width == '0) ? CNT_ONE : width;
    assign eff_p = (period > eff_w) ? period : (eff_w + CNT_ONE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            w_sh_q  <= '0;
            p_sh_q  <= '0;
            b_sh_q  <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            w_sh_q  <= w_sh_d;
            p_sh_q  <= p_sh_d;
            b_sh_q  <= b_sh_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    // cnt_q runs 1..w while high and w+1..p while low, so one period spans
    // exactly p cycles. Shadows are reloaded only at start and at period
    // boundaries, never mid-pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        w_sh_d  = w_sh_q;
        p_sh_d  = p_sh_q;
        b_sh_d  = b_sh_q;
        done_d  = 1'b0;

        if (start && enable) begin
            w_sh_d  = eff_w;
            p_sh_d  = eff_p;
            b_sh_d  = burst;
            cnt_d   = CNT_ONE;
            count_d = '0;
            state_d = ST_HIGH;
        end else if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_HIGH: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == w_sh_q) begin
                        state_d = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (cnt_q == p_sh_q) begin
                        count_d = count_q + CNT_ONE;
                        if ((b_sh_q != '0) && ((count_q + CNT_ONE) == b_sh_q)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            w_sh_d  = eff_w;
                            p_sh_d  = eff_p;
                            b_sh_d  = burst;
                            cnt_d   = CNT_ONE;
                            state_d = ST_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end

        // A software clear beats a same-cycle increment.
        if (count_clr) begin
            count_d = '0;
        end

        pulse_d = (state_d == ST_HIGH);
    end

    assign pulse_o  = pulse_q;
    assign done_irq = done_q;

endmodule

// File: tb/tb_tdc_pulsegen.sv
module tb_tdc_pulsegen;

    localparam logic [3:0] PAGE = 4'h2;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic [13:0] csr_a     = 14'd0;
    logic        csr_we    = 1'b0;
    logic [31:0] csr_di    = 32'd0;
    logic [31:0] csr_do;
    logic        pulse_o;
    logic        done_irq;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;
    int cyc      = 0;
    int last_wr_cyc = 0;

    tdc_pulsegen #(.csr_addr(PAGE), .cnt_width(24)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .csr_a     (csr_a),
        .csr_we    (csr_we),
        .csr_di    (csr_di),
        .csr_do    (csr_do),
        .pulse_o   (pulse_o),
        .done_irq  (done_irq)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A run is described by its phase index k within the current period:
    // the output is high while k < w, and the period ends when k == p-1.
    logic [23:0] m_period = 24'd2, m_width = 24'd1, m_burst = 24'd0, m_count = 24'd0;
    bit          m_en = 1'b0, m_active = 1'b0;
    int          m_k = 0, m_w = 1, m_p = 2, m_b = 0;
    logic [31:0] exp_do = 32'd0;
    logic        exp_pulse = 1'b0, exp_done = 1'b0;
    bit          mdl_sel, mdl_wr, mdl_en_now, mdl_start;
    logic [2:0]  mdl_idx;
    logic [31:0] mdl_rd;

    function automatic int eff_w(input logic [23:0] width);
        return (width == 0) ? 1 : int'(width);
    endfunction

    function automatic int eff_p(input logic [23:0] period, input int w);
        return (int'(period) > w) ? int'(period) : w + 1;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_period = 24'd2; m_width = 24'd1; m_burst = 24'd0; m_count = 24'd0;
            m_en = 1'b0; m_active = 1'b0; m_k = 0;
            exp_do = 32'd0; exp_pulse = 1'b0; exp_done = 1'b0;
        end else begin
            mdl_sel = (csr_a[13:10] == PAGE);
            mdl_idx = csr_a[2:0];
            mdl_wr  = mdl_sel && csr_we;
            case (mdl_idx)
                3'd0:    mdl_rd = {31'd0, m_en};
                3'd1:    mdl_rd = {8'd0, m_period};
                3'd2:    mdl_rd = {8'd0, m_width};
                3'd3:    mdl_rd = {8'd0, m_burst};
                3'd4:    mdl_rd = {8'd0, m_count};
                3'd5:    mdl_rd = {31'd0, m_active};
                default: mdl_rd = 32'd0;
            endcase
            exp_do     = mdl_sel ? mdl_rd : 32'd0;
            mdl_en_now = (mdl_wr && mdl_idx == 3'd0) ? csr_di[0] : m_en;
            mdl_start  = mdl_wr && (mdl_idx == 3'd0) && csr_di[1] && csr_di[0];
            exp_done   = 1'b0;
            if (mdl_start) begin
                m_w = eff_w(m_width); m_p = eff_p(m_period, m_w); m_b = int'(m_burst);
                m_active = 1'b1; m_k = 0; m_count = 24'd0;
            end else if (!mdl_en_now) begin
                m_active = 1'b0;
            end else if (m_active) begin
                if (m_k == m_p - 1) begin
                    m_count = m_count + 24'd1;
                    if (m_b != 0 && int'(m_count) == m_b) begin
                        m_active = 1'b0;
                        exp_done = 1'b1;
                    end else begin
                        m_w = eff_w(m_width); m_p = eff_p(m_period, m_w); m_b = int'(m_burst);
                        m_k = 0;
                    end
                end else begin
                    m_k++;
                end
            end
            if (mdl_wr && mdl_idx == 3'd4) m_count = 24'd0;
            if (mdl_wr) begin
                case (mdl_idx)
                    3'd0: m_en     = csr_di[0];
                    3'd1: m_period = csr_di[23:0];
                    3'd2: m_width  = csr_di[23:0];
                    3'd3: m_burst  = csr_di[23:0];
                    default: ;
                endcase
            end
            exp_pulse = m_active && (m_k < m_w);
        end
    end

    // ---------------- scoreboard: every cycle ----------------
    always @(negedge sys_clk) begin
        if (chk_on) begin
            check("pulse_o", {31'd0, pulse_o}, {31'd0, exp_pulse});
            check("done_irq", {31'd0, done_irq}, {31'd0, exp_done});
            check("csr_do", csr_do, exp_do);
        end
    end

    // ---------------- waveform monitor for literal checks ----------------
    int rise_q[$];
    int run_q[$];
    int high_cnt = 0, cur_run = 0, done_cnt = 0, done_cyc = -1;
    logic prev_pulse = 1'b0;

    always @(negedge sys_clk) begin
        if (pulse_o && !prev_pulse) rise_q.push_back(cyc);
        if (pulse_o) begin
            high_cnt++;
            cur_run++;
        end else if (prev_pulse) begin
            run_q.push_back(cur_run);
            cur_run = 0;
        end
        if (done_irq) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_pulse = pulse_o;
    end

    task automatic clear_mon();
        rise_q.delete();
        run_q.delete();
        high_cnt = 0; cur_run = 0; done_cnt = 0; done_cyc = -1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic csr_write(input logic [2:0] idx, input logic [31:0] data);
        @(negedge sys_clk);
        csr_a = {PAGE, 7'd0, idx};
        csr_di = data;
        csr_we = 1'b1;
        last_wr_cyc = cyc;
        @(negedge sys_clk);
        csr_we = 1'b0;
        csr_a  = 14'd0;
        csr_di = 32'd0;
    endtask

    task automatic csr_read(input logic [2:0] idx, output logic [31:0] data);
        @(negedge sys_clk);
        csr_a  = {PAGE, 7'd0, idx};
        csr_we = 1'b0;
        @(negedge sys_clk);
        data  = csr_do;
        csr_a = 14'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic read_check(input string name, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        csr_read(idx, d);
        check(name, d, exp);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] ctrl_tab [6] = '{32'd3, 32'd3, 32'd3, 32'd1, 32'd0, 32'd2};

    initial begin
        logic [3:0]  page;
        logic [2:0]  idx;
        logic [31:0] data;

        #1 sys_rst_n = 1'b0;
        idle(3);
        check("rst_pulse", {31'd0, pulse_o}, 32'd0);
        check("rst_done", {31'd0, done_irq}, 32'd0);
        check("rst_csr_do", csr_do, 32'd0);
        sys_rst_n = 1'b1;
        chk_on = 1'b1;

        // Reset values
        read_check("rst_ctrl",   3'd0, 32'd0);
        read_check("rst_period", 3'd1, 32'd2);
        read_check("rst_width",  3'd2, 32'd1);
        read_check("rst_burst",  3'd3, 32'd0);
        read_check("rst_count",  3'd4, 32'd0);
        read_check("rst_status", 3'd5, 32'd0);
        read_check("rst_idx6",   3'd6, 32'd0);
        read_check("rst_idx7",   3'd7, 32'd0);

        // Basic burst: 4 pulses, 3 high, period 10
        csr_write(3'd1, 32'd10);
        csr_write(3'd2, 32'd3);
        csr_write(3'd3, 32'd4);
        clear_mon();
        csr_write(3'd0, 32'd3);
        idle(50);
        check("burst_rises", rise_q.size(), 32'd4);
        if (rise_q.size() > 0) check("burst_first_rise", rise_q[0], last_wr_cyc + 1);
        for (int i = 1; i < rise_q.size(); i++) check("burst_spacing", rise_q[i] - rise_q[i-1], 32'd10);
        check("burst_high_cycles", high_cnt, 32'd12);
        check("burst_done_cnt", done_cnt, 32'd1);
        check("burst_done_cyc", done_cyc, last_wr_cyc + 41);
        read_check("burst_count", 3'd4, 32'd4);
        read_check("burst_status", 3'd5, 32'd0);

        // Clamping: width 0 -> 1, period 0 -> 2
        csr_write(3'd2, 32'd0);
        csr_write(3'd1, 32'd0);
        csr_write(3'd3, 32'd2);
        clear_mon();
        csr_write(3'd0, 32'd3);
        idle(10);
        check("clamp_rises", rise_q.size(), 32'd2);
        if (rise_q.size() == 2) check("clamp_spacing", rise_q[1] - rise_q[0], 32'd2);
        check("clamp_high_cycles", high_cnt, 32'd2);
        read_check("clamp_count", 3'd4, 32'd2);

        // Mid-run reprogram of PERIOD during a HIGH phase
        csr_write(3'd3, 32'd0);
        csr_write(3'd2, 32'd2);
        csr_write(3'd1, 32'd8);
        clear_mon();
        csr_write(3'd0, 32'd3);
        csr_write(3'd1, 32'd20);
        idle(50);
        check("reprog_rises", rise_q.size(), 32'd4);
        if (rise_q.size() >= 3) begin
            check("reprog_old_period", rise_q[1] - rise_q[0], 32'd8);
            check("reprog_new_period", rise_q[2] - rise_q[1], 32'd20);
        end
        if (run_q.size() >= 3) for (int i = 0; i < 3; i++) check("reprog_width", run_q[i], 32'd2);
        csr_write(3'd0, 32'd0);

        // Abort by clearing enable mid-HIGH
        csr_write(3'd1, 32'd6);
        csr_write(3'd2, 32'd3);
        csr_write(3'd3, 32'd5);
        clear_mon();
        csr_write(3'd0, 32'd3);
        idle(12);
        csr_write(3'd0, 32'd0);
        check("abort_pulse_low", {31'd0, pulse_o}, 32'd0);
        idle(20);
        check("abort_no_done", done_cnt, 32'd0);
        read_check("abort_count", 3'd4, 32'd2);
        read_check("abort_status", 3'd5, 32'd0);

        // Restart while busy during a LOW phase
        clear_mon();
        csr_write(3'd0, 32'd3);
        idle(8);
        csr_write(3'd0, 32'd3);
        check("restart_pulse_high", {31'd0, pulse_o}, 32'd1);
        read_check("restart_count", 3'd4, 32'd0);
        idle(40);
        check("restart_done_cnt", done_cnt, 32'd1);
        read_check("restart_final_count", 3'd4, 32'd5);

        // Asynchronous reset mid-HIGH
        csr_write(3'd3, 32'd0);
        csr_write(3'd1, 32'd7);
        csr_write(3'd2, 32'd4);
        csr_write(3'd0, 32'd3);
        #2 sys_rst_n = 1'b0;
        #1 check("async_rst_pulse", {31'd0, pulse_o}, 32'd0);
        idle(1);
        sys_rst_n = 1'b1;
        read_check("arst_ctrl",   3'd0, 32'd0);
        read_check("arst_period", 3'd1, 32'd2);
        read_check("arst_width",  3'd2, 32'd1);
        read_check("arst_burst",  3'd3, 32'd0);
        read_check("arst_count",  3'd4, 32'd0);

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge sys_clk);
            page = ($urandom_range(0, 9) < 7) ? PAGE : 4'($urandom_range(0, 15));
            idx  = 3'($urandom_range(0, 7));
            case (idx)
                3'd0:       data = ctrl_tab[$urandom_range(0, 5)];
                3'd1, 3'd2: data = 32'($urandom_range(0, 12));
                3'd3:       data = 32'($urandom_range(0, 5));
                default:    data = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) data = data | ($urandom & 32'hFF00_0000);
            csr_a  = {page, 7'($urandom), idx};
            csr_di = data;
            csr_we = ($urandom_range(0, 9) == 0);
        end
        @(negedge sys_clk);
        csr_we = 1'b0;
        csr_a  = 14'd0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
